// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Default FIFO depth, timeout length, entry layout and trigger-level encodings.
package uart_pkg;

    localparam int RX_FIFO_DEPTH    = 16;
    localparam int RX_TIMEOUT_TICKS = 4 * 10 * 16;
    localparam int RX_DATA_W        = 8;

    typedef struct packed {
        logic                 parity_err;
        logic                 frame_err;
        logic [RX_DATA_W-1:0] data;
    } rx_fifo_entry_t;

    typedef enum logic [1:0] {
        TRIG_ONE       = 2'b00,
        TRIG_QUARTER   = 2'b01,
        TRIG_HALF      = 2'b10,
        TRIG_NEAR_FULL = 2'b11
    } e_trig_lvl;

    function automatic int unsigned trig_level(input e_trig_lvl sel, input int unsigned depth);
        int unsigned lvl;
        case (sel)
            TRIG_ONE:       lvl = 1;
            TRIG_QUARTER:   lvl = depth / 4;
            TRIG_HALF:      lvl = depth / 2;
            TRIG_NEAR_FULL: lvl = depth - 2;
            default:        lvl = 1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_timer.sv
// Character timeout for the receive FIFO: fires after TICKS idle baud ticks with data held.
// Built into uart_rx_fifo only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo_timer
    import uart_pkg::*;
#(
    parameter int TICKS = RX_TIMEOUT_TICKS
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_baud,
    input  logic i_restart,
    input  logic i_active,
    output logic o_timeout
);

    localparam int            TW   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0] LOAD = TW'(TICKS - 1);

    logic [TW-1:0] remaining;

    // Down-counter: reaching zero on a tick is the TICKS-th idle tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            remaining <= LOAD;
            o_timeout <= 1'b0;
        end else if (i_restart) begin
            remaining <= LOAD;
            o_timeout <= 1'b0;
        end else if (i_active && i_baud) begin
            if (remaining == '0) begin
                o_timeout <= 1'b1;
            end else begin
                remaining <= remaining - TW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: stores characters with frame/parity error bits, first-word-fall-through read.
// Optional character timeout enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH,
    parameter int DATA_W = RX_DATA_W
`ifdef UART_RX_FIFO_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = RX_TIMEOUT_TICKS
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_wr_frame_err,
    input  logic                     i_wr_parity_err,
    output logic                     o_full,
    input  logic                     i_rd_en,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_frame_err,
    output logic                     o_rd_parity_err,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic                     i_flush,
    input  logic [1:0]               i_trig_sel,
    output logic                     o_trig_irq,
    output logic                     o_err_pending,
    output logic                     o_overrun,
    input  logic                     i_ovr_clr
`ifdef UART_RX_FIFO_TIMEOUT_EN
    ,
    input  logic                     i_baud,
    output logic                     o_timeout
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Same layout as rx_fifo_entry_t, sized by this instance's DATA_W.
    typedef struct packed {
        logic              parity_err;
        logic              frame_err;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          wr_entry;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   err_cnt;
    logic [CW-1:0]   err_cnt_nxt;
    logic [CW-1:0]   trig_lvl;
    logic            push_ok;
    logic            pop_ok;
    logic            push_err;
    logic            pop_err;
    logic            ovr_set;

    always_comb begin
        o_full   = (count == CW'(DEPTH));
        o_empty  = (count == '0);
        head     = mem[rd_ptr];
        wr_entry = '{parity_err: i_wr_parity_err, frame_err: i_wr_frame_err, data: i_wr_data};

        // A full FIFO still accepts a push when the head leaves in the same cycle.
        pop_ok   = i_rd_en && !o_empty && !i_flush;
        push_ok  = i_wr_en && (!o_full || pop_ok) && !i_flush;
        ovr_set  = i_wr_en && o_full && !pop_ok && !i_flush;

        push_err = i_wr_frame_err | i_wr_parity_err;
        pop_err  = head.frame_err | head.parity_err;
        trig_lvl = CW'(trig_level(e_trig_lvl'(i_trig_sel), DEPTH));
    end

    always_comb begin
        count_nxt   = count;
        err_cnt_nxt = err_cnt;
        if (i_flush) begin
            count_nxt   = '0;
            err_cnt_nxt = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
            case ({push_ok && push_err, pop_ok && pop_err})
                2'b10:   err_cnt_nxt = err_cnt + CW'(1);
                2'b01:   err_cnt_nxt = err_cnt - CW'(1);
                default: err_cnt_nxt = err_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_cnt    <= '0;
            o_trig_irq <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            end
            count      <= count_nxt;
            err_cnt    <= err_cnt_nxt;
            o_trig_irq <= (count_nxt >= trig_lvl);
            if (ovr_set) begin
                o_overrun <= 1'b1;
            end else if (i_ovr_clr) begin
                o_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        o_count         = count;
        o_err_pending   = (err_cnt != '0);
        o_rd_data       = o_empty ? '0   : head.data;
        o_rd_frame_err  = o_empty ? 1'b0 : head.frame_err;
        o_rd_parity_err = o_empty ? 1'b0 : head.parity_err;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    uart_rx_fifo_timer #(
        .TICKS (TIMEOUT_TICKS)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_baud    (i_baud),
        .i_restart (push_ok | pop_ok | i_flush | o_empty),
        .i_active  (!o_empty),
        .o_timeout (o_timeout)
    );
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue scoreboard of expected entries.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic              i_clk;
    logic              i_rst;
    logic              i_wr_en;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_wr_frame_err;
    logic              i_wr_parity_err;
    logic              o_full;
    logic              i_rd_en;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_frame_err;
    logic              o_rd_parity_err;
    logic              o_empty;
    logic [4:0]        o_count;
    logic              i_flush;
    logic [1:0]        i_trig_sel;
    logic              o_trig_irq;
    logic              o_err_pending;
    logic              o_overrun;
    logic              i_ovr_clr;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_wr_en         (i_wr_en),
        .i_wr_data       (i_wr_data),
        .i_wr_frame_err  (i_wr_frame_err),
        .i_wr_parity_err (i_wr_parity_err),
        .o_full          (o_full),
        .i_rd_en         (i_rd_en),
        .o_rd_data       (o_rd_data),
        .o_rd_frame_err  (o_rd_frame_err),
        .o_rd_parity_err (o_rd_parity_err),
        .o_empty         (o_empty),
        .o_count         (o_count),
        .i_flush         (i_flush),
        .i_trig_sel      (i_trig_sel),
        .o_trig_irq      (o_trig_irq),
        .o_err_pending   (o_err_pending),
        .o_overrun       (o_overrun),
        .i_ovr_clr       (i_ovr_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] sb [$];
    int         merr = 0;
    logic       movr = 1'b0;
    logic [7:0] last_pop = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lvl(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return DEPTH / 4;
            2'b10:   return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    task automatic check_state();
        logic [9:0] exp_head;
        exp_head = (sb.size() > 0) ? sb[0] : 10'h0;
        check("count",   32'(o_count), 32'(sb.size()));
        check("empty",   32'(o_empty), 32'(sb.size() == 0));
        check("full",    32'(o_full),  32'(sb.size() == DEPTH));
        check("err_pnd", 32'(o_err_pending), 32'(merr != 0));
        check("overrun", 32'(o_overrun), 32'(movr));
        check("trig",    32'(o_trig_irq), 32'(sb.size() >= lvl(i_trig_sel)));
        check("head",    32'({o_rd_parity_err, o_rd_frame_err, o_rd_data}), 32'(exp_head));
    endtask

    // One clock of stimulus; the scoreboard is updated with what should be accepted.
    task automatic cyc(input logic wr, input logic [7:0] d, input logic fe, input logic pe,
                       input logic rd, input logic fl, input logic clr);
        logic       pop_ok;
        logic       push_ok;
        logic       ovr_set;
        logic [9:0] hd;
        int         sz;
        sz = sb.size();
        i_wr_en = wr; i_wr_data = d; i_wr_frame_err = fe; i_wr_parity_err = pe;
        i_rd_en = rd; i_flush = fl; i_ovr_clr = clr;
        pop_ok  = rd && (sz > 0) && !fl;
        push_ok = wr && !fl && ((sz < DEPTH) || pop_ok);
        ovr_set = wr && !fl && (sz == DEPTH) && !pop_ok;
        if (pop_ok) begin
            hd = sb.pop_front();
            check("pop_head", 32'({o_rd_parity_err, o_rd_frame_err, o_rd_data}), 32'(hd));
            last_pop = hd[7:0];
            if (hd[9] | hd[8]) merr--;
        end
        if (fl) begin
            sb.delete();
            merr = 0;
        end
        if (push_ok) begin
            sb.push_back({pe, fe, d});
            if (fe | pe) merr++;
        end
        if (ovr_set) movr = 1'b1;
        else if (clr) movr = 1'b0;
        @(posedge i_clk);
        #1;
        i_wr_en = 1'b0; i_rd_en = 1'b0; i_flush = 1'b0; i_ovr_clr = 1'b0;
        i_wr_frame_err = 1'b0; i_wr_parity_err = 1'b0;
        check_state();
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        sb.delete();
        merr = 0;
        movr = 1'b0;
        check_state();
    endtask

    initial begin
        i_rst = 1'b1; i_wr_en = 1'b0; i_wr_data = '0; i_wr_frame_err = 1'b0;
        i_wr_parity_err = 1'b0; i_rd_en = 1'b0; i_flush = 1'b0; i_trig_sel = 2'b00;
        i_ovr_clr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();
        check("rst_empty",   32'(o_empty), 32'd1);
        check("rst_rd_data", 32'(o_rd_data), 32'd0);

        // Basic FWFT order
        push(8'h41); push(8'h42); push(8'h43);
        check("t1_count", 32'(o_count), 32'd3);
        check("t1_head",  32'(o_rd_data), 32'h41);
        pop();
        check("t1_head2", 32'(o_rd_data), 32'h42);
        pop();
        check("t1_head3", 32'(o_rd_data), 32'h43);
        pop();
        check("t1_empty", 32'(o_empty), 32'd1);
        check("t1_rd0",   32'(o_rd_data), 32'd0);
        pop();
        check("t1_pop_empty_cnt", 32'(o_count), 32'd0);

        // Fill, overflow, overrun clear and set-over-clear priority
        for (int i = 0; i < DEPTH; i++) push(8'(8'h60 + i));
        push(8'h99);
        check("t2_full",    32'(o_full), 32'd1);
        check("t2_count",   32'(o_count), 32'd16);
        check("t2_ovr",     32'(o_overrun), 32'd1);
        check("t2_head",    32'(o_rd_data), 32'h60);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_ovr_clr", 32'(o_overrun), 32'd0);
        cyc(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_set_wins", 32'(o_overrun), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Push and pop together while full
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_count", 32'(o_count), 32'd16);
        check("t3_ovr",   32'(o_overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop();
        check("t3_last",  32'(last_pop), 32'h55);

        // Push and pop together while empty
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_empty_pp", 32'(o_count), 32'd1);
        pop();

        // Trigger level at DEPTH/2
        i_trig_sel = 2'b10;
        for (int i = 0; i < 7; i++) push(8'(8'h70 + i));
        check("t4_trig7", 32'(o_trig_irq), 32'd0);
        push(8'h77);
        check("t4_trig8", 32'(o_trig_irq), 32'd1);
        pop();
        check("t4_trig_pop", 32'(o_trig_irq), 32'd0);
        i_trig_sel = 2'b11;
        for (int i = 0; i < 7; i++) push(8'(8'h80 + i));
        check("t4_trig14", 32'(o_trig_irq), 32'd1);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_flush_push", 32'(o_count), 32'd0);
        i_trig_sel = 2'b00;

        // Error tracking and flush
        cyc(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(8'h20);
        check("t5_err1", 32'(o_err_pending), 32'd1);
        check("t5_head_pe", 32'(o_rd_parity_err), 32'd1);
        pop();
        check("t5_err0", 32'(o_err_pending), 32'd0);
        cyc(1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h22); push(8'h23); push(8'h24);
        check("t5_count5", 32'(o_count), 32'd5);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_flush_cnt", 32'(o_count), 32'd0);
        check("t5_flush_emp", 32'(o_empty), 32'd1);
        check("t5_flush_err", 32'(o_err_pending), 32'd0);

        // Reset mid-operation with overrun and error entries held
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'hA0 + i), i[0], 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'hFF);
        check("t6_pre_ovr", 32'(o_overrun), 32'd1);
        do_reset();
        check("t6_rst_ovr", 32'(o_overrun), 32'd0);
        check("t6_rst_err", 32'(o_err_pending), 32'd0);
        push(8'h5A);
        check("t6_after_rst", 32'(o_rd_data), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive FIFO directly downstream of the UART receiver.
- Captures each received character together with its per-character frame/parity error bits on the receiver's write strobe.
- Presents the head entry first-word-fall-through to the TL-UL register/read side.
- Generates full/empty, fill count, trigger-level interrupt, sticky overrun and error-pending status.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
DATA_W, 8, character width (5–7 bit characters arrive zero-extended in the upper bits)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_wr_en  in  1  push strobe from receiver (rx done)
i_wr_data  in  DATA_W  received character
i_wr_frame_err  in  1  stop-bit error for this character
i_wr_parity_err  in  1  parity error for this character
o_full  out  1  FIFO full (to receiver's FIFO-full input)
i_rd_en  in  1  pop head entry
o_rd_data  out  DATA_W  head character (0 when empty)
o_rd_frame_err  out  1  head entry frame error (0 when empty)
o_rd_parity_err  out  1  head entry parity error (0 when empty)
o_empty  out  1  FIFO empty
o_count  out  $clog2(DEPTH)+1  entries held
i_flush  in  1  discard all entries
i_trig_sel  in  2  trigger level: 00=1, 01=DEPTH/4, 10=DEPTH/2, 11=DEPTH-2
o_trig_irq  out  1  o_count >= selected trigger level
o_err_pending  out  1  at least one held entry has frame or parity error
o_overrun  out  1  sticky: a write was dropped while full
i_ovr_clr  in  1  clear o_overrun

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values:
  - Pointers, count and error-entry count = 0.
  - o_empty = 1; o_full, o_trig_irq, o_err_pending, o_overrun = 0.
  - o_rd_* = 0.
  - Memory contents need no reset.
- Storage: entry = {parity_err, frame_err, data}, written at wr_ptr. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. Count is registered.
- Read side: o_rd_* combinationally reflect mem[rd_ptr] when not empty, else 0.
- Write latency: a push into an empty FIFO is visible on o_rd_* and o_empty=0 in the following cycle.
- Push: i_wr_en and not full -> store entry, wr_ptr+1, count+1.
- Pop: i_rd_en and not empty -> rd_ptr+1, count-1. Pop while empty is ignored (no pointer change, no flag).
- Simultaneous push and pop:
  - Not empty and not full: both occur, count unchanged.
  - Full: pop and push both accepted, count stays DEPTH, no overrun.
  - Empty: push accepted, pop ignored, count becomes 1.
- Overrun: push while full with no pop -> entry dropped, o_overrun set next cycle.
  - Held until i_ovr_clr.
  - Set and clear in the same cycle: set wins.
- i_flush:
  - Highest priority. Pointers, count and error-entry count go to 0 next cycle.
  - Any concurrent push or pop is discarded.
  - o_overrun is unaffected.
- o_full = (count == DEPTH); o_empty = (count == 0). Both derived from the registered count.
- o_trig_irq: registered compare of the next count against the level selected by i_trig_sel. A change of i_trig_sel takes effect the next cycle.
- o_err_pending: an error-entry counter increments on push of an entry with either error bit set, and decrements on pop of such an entry. o_err_pending = (counter != 0).
- Reset asserted mid-operation: all state returns to reset values next edge; queued data is lost.

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- When defined, the block adds:
  - Port i_baud (1, oversample tick).
  - Parameter TIMEOUT_TICKS (default 4*10*16 = 640).
  - Output o_timeout.
- Timer behaviour:
  - A timer counts i_baud ticks while the FIFO is non-empty and no push or pop occurs.
  - The timer resets to 0 on any push, pop, flush or empty.
  - o_timeout is set when the timer reaches TIMEOUT_TICKS-1 on a tick, and holds until the next pop, push or flush.
- When undefined: no i_baud, no o_timeout, no timer logic.

Decomposition:
- Package uart_pkg holds:
  - Typedef rx_fifo_entry_t (packed struct: parity_err, frame_err, data).
  - Typedef e_trig_lvl enum for i_trig_sel encodings.
  - Default constants RX_FIFO_DEPTH=16 and RX_TIMEOUT_TICKS=640.
- Sub-module uart_rx_fifo_timer contains the timeout counter; it is instantiated only under UART_RX_FIFO_TIMEOUT_EN.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 -> count=3, o_rd_data=0x41; pop x3 -> 0x42, 0x43, then o_empty=1 and o_rd_data=0.
- Fill 16 entries, then push 0x99 with no pop -> o_full=1, count=16, o_overrun=1, head unchanged; i_ovr_clr -> o_overrun=0.
- While full, push 0x55 and pop in the same cycle -> count stays 16, no overrun, 0x55 is read last.
- i_trig_sel=10, push 7 entries -> o_trig_irq=0; 8th push -> o_trig_irq=1; one pop -> 0.
- Push 0x10 with parity_err=1, then 0x20 clean -> o_err_pending=1; pop the first -> o_err_pending=0; flush with 5 entries -> count=0, o_empty=1.
- (TIMEOUT_EN) 1 entry held, 640 i_baud ticks with no access -> o_timeout=1 on the last tick; pop -> o_timeout=0.
